// File: rtl/apb_pkg.sv
// Shared APB definitions: bus width defaults, FSM state encoding and register map constants.
package apb_pkg;

  localparam int          APB_ADDR_W   = 8;
  localparam int          APB_DATA_W   = 8;
  localparam logic [7:0]  APB_ID_VALUE = 8'hA5;

  localparam logic [7:0]  REG_ID       = 8'h00;
  localparam logic [7:0]  REG_FIRST_RW = 8'h01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_reg_file.sv
// Byte-wide register file behind the APB slave: storage, read mux and address decode.
module apb_reg_file
  import apb_pkg::*;
#(
  parameter int                ADDR_W   = APB_ADDR_W,
  parameter int                DATA_W   = APB_DATA_W,
  parameter int                NUM_REGS = 16,
  parameter logic [DATA_W-1:0] ID_VALUE = DATA_W'(APB_ID_VALUE)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_addr_valid,
  output logic              o_read_only
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_wvalid;
  logic              w_wro;

  assign w_wvalid = int'(i_waddr) < NUM_REGS;
  assign w_wro    = i_waddr < ADDR_W'(REG_FIRST_RW);

  // Entry 0 is never written; the ID constant is muxed in on reads instead.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && w_wvalid && !w_wro) begin
      r_regs[i_waddr[IDX_W-1:0]] <= i_wdata;
    end
  end

  always_comb begin
    o_addr_valid = int'(i_raddr) < NUM_REGS;
    o_read_only  = i_raddr < ADDR_W'(REG_FIRST_RW);
    o_rdata      = '0;
    if (i_raddr == ADDR_W'(REG_ID)) begin
      o_rdata = ID_VALUE;
    end else if (o_addr_valid) begin
      o_rdata = r_regs[i_raddr[IDX_W-1:0]];
    end
  end

endmodule

// File: rtl/apb_reg_slave.sv
// APB completer with programmable wait states; outputs are registered one cycle ahead of use.
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter int                ADDR_W      = APB_ADDR_W,
  parameter int                DATA_W      = APB_DATA_W,
  parameter int                NUM_REGS    = 16,
  parameter int                WAIT_CYCLES = 1,
  parameter logic [DATA_W-1:0] ID_VALUE    = DATA_W'(APB_ID_VALUE)
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic              pready,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  apb_state_t        r_state;
  apb_state_t        w_stateNext;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cntNext;
  logic              r_pready;
  logic [DATA_W-1:0] r_prdata;
  logic              r_pslverr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;

  logic              w_capture;
  logic              w_readyNext;
  logic [ADDR_W-1:0] w_addr;
  logic              w_write;
  logic [DATA_W-1:0] w_rdata;
  logic              w_valid;
  logic              w_ro;
  logic              w_err;
  logic              w_we;

  // SETUP covers the first penable cycle after capture; pready is decided one edge early
  // so that it is a flop output in the completing cycle.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_capture   = 1'b0;
    w_readyNext = 1'b0;
    case (r_state)
      IDLE: begin
        if (psel && !penable) begin
          w_stateNext = SETUP;
          w_capture   = 1'b1;
          w_cntNext   = WAIT_LD;
          w_readyNext = (WAIT_CYCLES == 0);
        end
      end
      SETUP, ACCESS: begin
        if (r_pready || !psel) begin
          w_stateNext = IDLE;
        end else begin
          w_stateNext = ACCESS;
          w_cntNext   = r_cnt - 4'd1;
          w_readyNext = (r_cnt <= 4'd1);
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign w_addr  = w_capture ? paddr  : r_addr;
  assign w_write = w_capture ? pwrite : r_write;
  assign w_err   = !w_valid || (w_write && w_ro);
  assign w_we    = r_pready && r_write && !r_pslverr;

  apb_reg_file #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ID_VALUE(ID_VALUE)
  ) u_regs (
    .i_clk       (pclk),
    .i_rst_n     (preset_n),
    .i_we        (w_we),
    .i_waddr     (r_addr),
    .i_wdata     (r_wdata),
    .i_raddr     (w_addr),
    .o_rdata     (w_rdata),
    .o_addr_valid(w_valid),
    .o_read_only (w_ro)
  );

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pready  <= 1'b0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_cnt     <= w_cntNext;
      r_pready  <= w_readyNext;
      r_pslverr <= w_readyNext && w_err;
      r_prdata  <= (w_readyNext && !w_err && !w_write) ? w_rdata : '0;
      if (w_capture) begin
        r_addr  <= paddr;
        r_write <= pwrite;
        r_wdata <= pwdata;
      end
    end
  end

  assign pready  = r_pready;
  assign prdata  = r_prdata;
  assign pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Self-checking bench: three slaves (WAIT_CYCLES 1, 0, 3) on one bus, each with its own psel.
module tb_apb_reg_slave;

  logic       pclk = 1'b0;
  logic       preset_n;
  logic [2:0] sel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [2:0] rdy;
  logic [2:0] err;
  logic [7:0] rd [3];

  always #5 pclk = ~pclk;

  apb_reg_slave #(.WAIT_CYCLES(1)) u0 (
    .pclk(pclk), .preset_n(preset_n), .psel(sel[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(rdy[0]), .prdata(rd[0]), .pslverr(err[0]));
  apb_reg_slave #(.WAIT_CYCLES(0)) u1 (
    .pclk(pclk), .preset_n(preset_n), .psel(sel[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(rdy[1]), .prdata(rd[1]), .pslverr(err[1]));
  apb_reg_slave #(.WAIT_CYCLES(3)) u2 (
    .pclk(pclk), .preset_n(preset_n), .psel(sel[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(rdy[2]), .prdata(rd[2]), .pslverr(err[2]));

  int         waitOf [3] = '{1, 0, 3};
  int         total = 0;
  int         bad = 0;
  logic [7:0] model [3][16];
  int         curDut = 0;
  logic       expPready = 1'b0;
  logic [7:0] expPrdata = 8'h00;
  logic       expPslverr = 1'b0;
  bit         checkEn = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 16; i++) begin
        model[d][i] = (i == 0) ? 8'hA5 : 8'h00;
      end
    end
  endtask

  // Per-cycle comparison of every slave against the bench's expectation for this cycle.
  always @(negedge pclk) begin
    logic       eRdy;
    logic [7:0] eRd;
    logic       eErr;
    if (checkEn) begin
      for (int i = 0; i < 3; i++) begin
        eRdy = (i == curDut) ? expPready : 1'b0;
        eRd  = eRdy ? expPrdata : 8'h00;
        eErr = eRdy ? expPslverr : 1'b0;
        checkOutput($sformatf("cyc_pready%0d", i), 32'(rdy[i]), 32'(eRdy));
        checkOutput($sformatf("cyc_prdata%0d", i), 32'(rd[i]), 32'(eRd));
        checkOutput($sformatf("cyc_pslverr%0d", i), 32'(err[i]), 32'(eErr));
      end
    end
  end

  // One APB transfer: setup cycle, then penable cycles until the model says pready.
  task automatic applyStimulus(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                               input int abortAt, input bit doReset,
                               output logic [7:0] rdOut, output bit errOut, output int latOut);
    int         lat;
    bit         e;
    logic [7:0] r;
    e      = (a >= 8'd16) || (wr && a == 8'h00);
    r      = (wr || e) ? 8'h00 : model[d][a[3:0]];
    lat    = waitOf[d] + 1;
    latOut = -1;
    rdOut  = 8'h00;
    errOut = 1'b0;
    @(posedge pclk) #1;
    curDut = d; sel = 3'b001 << d; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = wd;
    expPready = 1'b0; expPrdata = 8'h00; expPslverr = 1'b0;
    @(negedge pclk);
    for (int k = 1; k <= lat; k++) begin
      @(posedge pclk) #1;
      penable = 1'b1; paddr = a ^ 8'h5A; pwdata = ~wd; pwrite = ~wr;
      if (k == abortAt) begin
        sel = 3'b000; penable = 1'b0; expPready = 1'b0;
      end else begin
        expPready  = (k == lat);
        expPrdata  = (k == lat) ? r : 8'h00;
        expPslverr = (k == lat) ? e : 1'b0;
      end
      if (doReset && k == lat) begin
        checkEn = 1'b0;
        checkOutput("pready_before_reset", 32'(rdy[d]), 32'd1);
        #1 preset_n = 1'b0;
        #1;
        checkOutput("reset_async_pready", 32'(rdy[d]), 32'd0);
        checkOutput("reset_async_prdata", 32'(rd[d]), 32'd0);
        modelReset();
        sel = 3'b000; penable = 1'b0; expPready = 1'b0;
        @(posedge pclk) #1 preset_n = 1'b1;
        @(negedge pclk) checkEn = 1'b1;
        return;
      end
      @(negedge pclk);
      if (rdy[d] && latOut < 0) begin
        latOut = k; rdOut = rd[d]; errOut = err[d];
      end
      if (k == abortAt) return;
    end
    if (wr && !e) model[d][a[3:0]] = wd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk) #1;
      sel = 3'b000; penable = 1'b0; expPready = 1'b0;
      @(negedge pclk);
    end
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] v;
    bit         e;
    int         lat;
    preset_n = 1'b0; sel = 3'b000; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 8'h00;
    modelReset();
    repeat (2) @(negedge pclk);
    for (int i = 0; i < 3; i++) begin
      checkOutput("reset_pready", 32'(rdy[i]), 32'd0);
      checkOutput("reset_prdata", 32'(rd[i]), 32'd0);
      checkOutput("reset_pslverr", 32'(err[i]), 32'd0);
    end
    @(posedge pclk) #1 preset_n = 1'b1;
    @(negedge pclk) checkEn = 1'b1;

    applyStimulus(0, 1'b0, 8'h00, 8'h00, -1, 1'b0, r, e, lat);
    checkOutput("id_read", 32'(r), 32'hA5);
    checkOutput("id_err", 32'(e), 32'd0);
    checkOutput("id_latency", 32'(lat), 32'd2);
    idle(1);

    for (int i = 0; i < 5; i++) begin
      v = 8'($urandom);
      applyStimulus(0, 1'b1, 8'h01, v, -1, 1'b0, r, e, lat);
      checkOutput("rw_write_err", 32'(e), 32'd0);
      applyStimulus(0, 1'b0, 8'h01, 8'h00, -1, 1'b0, r, e, lat);
      checkOutput("rw_readback", 32'(r), 32'(v));
      checkOutput("rw_read_err", 32'(e), 32'd0);
      idle(1);
    end
    applyStimulus(0, 1'b0, 8'h02, 8'h00, -1, 1'b0, r, e, lat);
    checkOutput("reg2_untouched", 32'(r), 32'h00);

    applyStimulus(0, 1'b1, 8'h00, 8'h3C, -1, 1'b0, r, e, lat);
    checkOutput("ro_write_err", 32'(e), 32'd1);
    applyStimulus(0, 1'b0, 8'h00, 8'h00, -1, 1'b0, r, e, lat);
    checkOutput("ro_still_id", 32'(r), 32'hA5);
    applyStimulus(0, 1'b0, 8'h20, 8'h00, -1, 1'b0, r, e, lat);
    checkOutput("unmapped_err", 32'(e), 32'd1);
    checkOutput("unmapped_data", 32'(r), 32'h00);
    idle(2);

    for (int d = 0; d < 3; d++) begin
      applyStimulus(d, 1'b1, 8'h05, 8'h11, -1, 1'b0, r, e, lat);
      checkOutput($sformatf("b2b_latency%0d", d), 32'(lat), 32'(d == 0 ? 2 : (d == 1 ? 1 : 4)));
      applyStimulus(d, 1'b1, 8'h06, 8'h22, -1, 1'b0, r, e, lat);
      applyStimulus(d, 1'b0, 8'h05, 8'h00, -1, 1'b0, r, e, lat);
      checkOutput($sformatf("b2b_read05_%0d", d), 32'(r), 32'h11);
      applyStimulus(d, 1'b0, 8'h06, 8'h00, -1, 1'b0, r, e, lat);
      checkOutput($sformatf("b2b_read06_%0d", d), 32'(r), 32'h22);
      idle(1);
    end

    applyStimulus(0, 1'b1, 8'h03, 8'h77, -1, 1'b0, r, e, lat);
    applyStimulus(0, 1'b1, 8'h03, 8'h99, 1, 1'b0, r, e, lat);
    checkOutput("abort_no_pready", 32'(lat), 32'hFFFF_FFFF);
    idle(3);
    applyStimulus(0, 1'b0, 8'h03, 8'h00, -1, 1'b0, r, e, lat);
    checkOutput("abort_kept", 32'(r), 32'h77);
    applyStimulus(2, 1'b1, 8'h03, 8'h44, 2, 1'b0, r, e, lat);
    idle(4);
    applyStimulus(2, 1'b0, 8'h03, 8'h00, -1, 1'b0, r, e, lat);
    checkOutput("abort_kept_w3", 32'(r), 32'h00);

    @(posedge pclk) #1;
    curDut = 0; sel = 3'b001; penable = 1'b1; expPready = 1'b0;
    repeat (3) @(negedge pclk);
    idle(1);

    applyStimulus(0, 1'b1, 8'h04, 8'hFF, -1, 1'b1, r, e, lat);
    idle(1);
    applyStimulus(0, 1'b0, 8'h04, 8'h00, -1, 1'b0, r, e, lat);
    checkOutput("reset_cleared04", 32'(r), 32'h00);
    applyStimulus(0, 1'b0, 8'h05, 8'h00, -1, 1'b0, r, e, lat);
    checkOutput("reset_cleared05", 32'(r), 32'h00);
    applyStimulus(1, 1'b0, 8'h06, 8'h00, -1, 1'b0, r, e, lat);
    checkOutput("reset_cleared06_w0", 32'(r), 32'h00);
    idle(2);

    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_reg_slave.md
Name: apb_reg_slave

Overview:
- APB responder (completer) holding the byte-wide register file that the CPU bus model targets with apb_write/apb_read.
- Sits at the far end of the APB link inside the testbench top.
- Decodes an 8-bit address, inserts a programmable number of wait states, returns read data, and flags illegal accesses with pslverr.
- Used as the DUT for write/read/check regression tests.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- NUM_REGS, 16, number of decoded registers (addresses 0x00..NUM_REGS-1).
- WAIT_CYCLES, 1, wait states inserted before pready (0..15).
- ID_VALUE, 8'hA5, constant returned at address 0x00.

Ports:
- pclk  input  1  APB clock; all logic on rising edge.
- preset_n  input  1  reset, asynchronous, active-low.
- psel  input  1  slave select.
- penable  input  1  access-phase strobe.
- pwrite  input  1  1=write, 0=read.
- paddr  input  ADDR_W  byte address.
- pwdata  input  DATA_W  write data.
- pready  output  1  transfer complete.
- prdata  output  DATA_W  read data, valid only while pready=1.
- pslverr  output  1  error response, valid only while pready=1.

Behaviour:
- Reset (preset_n=0, async): state=IDLE, wait counter=0, pready=0, prdata=0, pslverr=0, registers 0x01..NUM_REGS-1 cleared to 0x00.
- Register map:
  - 0x00 is read-only ID_VALUE.
  - 0x01..NUM_REGS-1 are RW.
  - paddr>=NUM_REGS is unmapped.
- FSM states are IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when psel=1 and penable=0. Counter loads WAIT_CYCLES.
  - SETUP -> ACCESS next cycle (master raises penable).
  - In ACCESS with counter>0: counter decrements, pready=0.
  - In ACCESS with counter==0: pready=1 for exactly one cycle, then go to IDLE, or to SETUP if psel=1 and penable=0 on the following cycle (back-to-back transfers).
- Latency: pready rises in the (WAIT_CYCLES+1)-th cycle with penable=1. WAIT_CYCLES=0 gives a zero-wait transfer, i.e. a 2-cycle APB transfer.
- pready, prdata and pslverr are registered outputs. When pready=0, prdata and pslverr are 0.
- Write commit: the register updates on the rising edge that ends the pready=1 cycle, and only if pslverr=0. A read in the following transfer returns the new value.
- Read: prdata = register[paddr], sampled at the start of the completing cycle.
- pslverr=1 (asserted with pready) in two cases:
  - unmapped address, read or write;
  - write to 0x00.
  - In both cases no register changes; prdata=0.
- paddr, pwrite and pwdata are captured in SETUP and held internally. Later changes by the master during ACCESS are ignored.
- Protocol abort: psel drops to 0 in SETUP or ACCESS before pready -> return to IDLE, no write, no pready.
- penable=1 while in IDLE (no setup phase) is ignored.
- Reset mid-transfer: outputs go to reset values immediately, the transfer is dropped, and the register file is cleared.

Decomposition:
- Shared package apb_pkg holds:
  - the ADDR_W/DATA_W defaults;
  - the state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2);
  - ID_VALUE;
  - the address constants REG_ID=8'h00 and REG_FIRST_RW=8'h01.
- One sub-module, apb_reg_file: NUM_REGS x DATA_W storage with a write-enable port, async clear, a read mux, and the address-valid / read-only decode. The FSM and wait counter stay in apb_reg_slave.

Test Plan:
- Reset, then apb_read(0x00) -> prdata=0xA5, pslverr=0, pready high after exactly 1 wait cycle (WAIT_CYCLES=1).
- Five random loops of apb_write(0x01, d) then apb_read(0x01) -> rdata==d each time, pslverr=0. Also read 0x02 -> 0x00 (unaffected).
- apb_write(0x00, 0x3C) -> pslverr=1; then apb_read(0x00) -> 0xA5. apb_read(0x20) -> pslverr=1, prdata=0x00.
- Back-to-back: write 0x05=0x11, write 0x06=0x22, read 0x05 with no idle cycles between -> 0x11, then read 0x06 -> 0x22. Rebuild with WAIT_CYCLES=0 -> each transfer exactly 2 cycles. Rebuild with WAIT_CYCLES=3 -> pready on the 4th penable cycle.
- Write 0x03=0x77; start write 0x03=0x99 and drop psel during a wait cycle -> no pready, read 0x03 -> 0x77.
- Write 0x04=0xFF; assert preset_n=0 mid-ACCESS -> pready=0 immediately; after release, read 0x04 -> 0x00.
